// File: rtl/vga_frame_commit_pkg.sv
// Shared constants, FSM encoding and helpers for the VGA tear-free commit block.
package vga_frame_commit_pkg;

    // Default word address of shadow word 0; the block decodes ten words from here.
    localparam logic [12:0] BASE_DEFAULT = 13'h1000;
    localparam logic [12:0] NUM_WORDS    = 13'd10;

    // Register offsets relative to BASE.
    localparam logic [3:0] OFF_CTRL   = 4'd8;
    localparam logic [3:0] OFF_STATUS = 4'd9;

    // CTRL write bits.
    localparam int unsigned CTRL_ARM_BIT   = 0;
    localparam int unsigned CTRL_FORCE_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // STATUS word: frame count in the top half, armed flag and dirty bits at the bottom.
    function automatic logic [31:0] status_word(input logic [15:0] fc,
                                                input logic        armed,
                                                input logic [1:0]  dirty);
        return {fc, 13'b0, armed, dirty};
    endfunction

    // CTRL readback only exposes the armed flag in bit 1.
    function automatic logic [31:0] ctrl_word(input logic armed);
        return {30'b0, armed, 1'b0};
    endfunction

endpackage

// File: rtl/vga_frame_commit_vs_edge_sync.sv
// Brings the asynchronous active-low VGA vertical sync into the processor clock
// domain and flags its falling edge (start of vertical sync) for one cycle.
module vs_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vs_i,
    output logic vs_fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= vs_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // High-to-low transition of the synchronized VS.
    always_comb begin
        vs_fall_o = s3_q & ~s2_q;
    end

endmodule

// File: rtl/vga_frame_commit.sv
// Tear-free update scheduler: processor stores land in shadow registers, which are
// copied onto the live p1VGA/p2VGA buses only at the start of vertical sync (when
// armed) or immediately on a force write.
module vga_frame_commit
    import vga_frame_commit_pkg::*;
#(
    parameter logic [12:0] BASE    = BASE_DEFAULT,
    parameter int          FRAME_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [12:0]        address,
    input  logic [31:0]        data_in,
    input  logic               wren,
    input  logic               vga_vs,
    output logic               hit,
    output logic [31:0]        data_out,
    output logic [127:0]       p1VGA,
    output logic [127:0]       p2VGA,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count
);

    state_e               state_q, state_d;
    logic [1:0][127:0]    shadow_q, shadow_d;
    logic [127:0]         p1_q, p1_d;
    logic [127:0]         p2_q, p2_d;
    logic [1:0]           dirty_q, dirty_d;
    logic                 frame_done_q, frame_done_d;
    logic [FRAME_W-1:0]   frame_count_q, frame_count_d;

    logic [12:0]          offset_s;
    logic [3:0]           off4_s;
    logic                 hit_s;
    logic                 shadow_wr_s;
    logic                 ctrl_wr_s;
    logic                 arm_wr_s;
    logic                 force_wr_s;
    logic                 vs_fall_s;
    logic                 armed_s;

    vs_edge_sync u_vs_sync (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .vs_i      (vga_vs),
        .vs_fall_o (vs_fall_s)
    );

    // Address decode; addresses below BASE wrap to large offsets and miss.
    always_comb begin
        offset_s    = address - BASE;
        off4_s      = offset_s[3:0];
        hit_s       = (offset_s < NUM_WORDS);
        shadow_wr_s = wren & hit_s & (off4_s < OFF_CTRL);
        ctrl_wr_s   = wren & hit_s & (off4_s == OFF_CTRL);
        arm_wr_s    = ctrl_wr_s & data_in[CTRL_ARM_BIT];
        force_wr_s  = ctrl_wr_s & data_in[CTRL_FORCE_BIT];
        armed_s     = (state_q == ST_ARMED);
    end

    // Next-state logic for shadows, dirty flags, live buses, frame counter and FSM.
    always_comb begin
        shadow_d      = shadow_q;
        dirty_d       = dirty_q;
        p1_d          = p1_q;
        p2_d          = p2_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        state_d       = state_q;

        if (vs_fall_s) begin
            frame_count_d = frame_count_q + FRAME_W'(1);
        end else begin
            frame_count_d = frame_count_q;
        end

        // Commit reads the pre-write shadow; a same-cycle store re-dirties below.
        if (state_q == ST_COMMIT) begin
            if (dirty_q[0]) begin
                p1_d = shadow_q[0];
            end else begin
                p1_d = p1_q;
            end
            if (dirty_q[1]) begin
                p2_d = shadow_q[1];
            end else begin
                p2_d = p2_q;
            end
            dirty_d      = 2'b00;
            frame_done_d = 1'b1;
        end else begin
            frame_done_d = 1'b0;
        end

        if (shadow_wr_s) begin
            shadow_d[off4_s[2]][{off4_s[1:0], 5'b00000} +: 32] = data_in;
            dirty_d[off4_s[2]] = 1'b1;
        end else begin
            dirty_d = dirty_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (force_wr_s) begin
                    state_d = ST_COMMIT;
                end else if (arm_wr_s) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (force_wr_s || vs_fall_s) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_COMMIT: begin
                if (arm_wr_s) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            dirty_q       <= 2'b00;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            dirty_q       <= dirty_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Combinational readback mux; misses return zero.
    always_comb begin
        data_out = 32'h0;
        if (hit_s) begin
            if (off4_s < OFF_CTRL) begin
                data_out = shadow_q[off4_s[2]][{off4_s[1:0], 5'b00000} +: 32];
            end else if (off4_s == OFF_CTRL) begin
                data_out = ctrl_word(armed_s);
            end else begin
                data_out = status_word(16'(frame_count_q), armed_s, dirty_q);
            end
        end else begin
            data_out = 32'h0;
        end
    end

    // Output drive from registers (hit is the only decode-level output).
    always_comb begin
        hit         = hit_s;
        p1VGA       = p1_q;
        p2VGA       = p2_q;
        frame_done  = frame_done_q;
        frame_count = frame_count_q;
    end

endmodule

// File: doc/vga_frame_commit.md
Name: vga_frame_commit

Overview:
- Tear-free update scheduler between the processor's memory-mapped store path and the VGA controller's player sprite buses p1VGA/p2VGA (128 bits each).
- Processor stores land in shadow registers.
- The block commits those shadow registers to the live VGA buses only at the start of vertical sync, or immediately when forced.
- It sits inside the mmio address decode, alongside dmem and GPIO.

Parameters:
- BASE, 13'h1000: word address of shadow word 0; block decodes BASE..BASE+9.
- FRAME_W, 16: width of the frame counter.

Ports:
- clock  in  1  system clock (processor/dmem clock)
- reset_n  in  1  asynchronous, active-low reset
- address  in  13  dmem word address from processor
- data_in  in  32  store data
- wren  in  1  store strobe, one cycle per store
- vga_vs  in  1  VGA VS from VGA_CLK domain, active-low, asynchronous to clock
- hit  out  1  combinational: address within BASE..BASE+9
- data_out  out  32  combinational readback
- p1VGA  out  128  live player-1 sprite/state bus
- p2VGA  out  128  live player-2 sprite/state bus
- frame_done  out  1  one-cycle pulse in the cycle after a commit
- frame_count  out  FRAME_W  VS falling edges counted since reset

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0:
  - p1VGA, p2VGA, shadows, dirty[1:0], frame_done, frame_count
  - synchronizer flops; FSM enters IDLE.
- Address map, offset = address - BASE:
  - 0-3: P1 shadow bits [32k+31:32k].
  - 4-7: P2 shadow, same mapping for k = offset-4.
  - 8: CTRL. Write bit0 = arm; write bit1 = force.
  - 9: STATUS, read-only; writes ignored.
- Shadow write (wren & offset 0-7): the word updates at the clock edge; dirty[player] is set.
- Readback:
  - offset 0-7 returns the shadow word.
  - offset 8 returns {30'b0, state==ARMED, 1'b0}.
  - offset 9 returns {frame_count zero-extended to 16, 13'b0, state==ARMED, dirty[1], dirty[0]}.
  - Not hit: returns 0.
- VS sync: two flops s1, s2, plus s3 = previous s2. vs_fall = s3 & ~s2.
  - frame_count increments on every vs_fall, in any state, and wraps at 2^FRAME_W.
- FSM:
  - IDLE -> ARMED on a CTRL write with bit0 = 1.
  - IDLE or ARMED -> COMMIT on a CTRL write with bit1 = 1 (force has priority over arm).
  - ARMED -> COMMIT when vs_fall.
  - COMMIT, one cycle:
    - p1VGA <= shadow1 if dirty[0]; p2VGA <= shadow2 if dirty[1]; a clean player keeps its value.
    - Clear the committed dirty bits; frame_done <= 1 (visible the next cycle).
    - Next state is ARMED if a CTRL arm write occurs in this cycle, otherwise IDLE.
- Latency:
  - If vga_vs is first sampled low at edge t0, the live buses change at edge t3.
  - A force write at edge t0 gives live buses changed at t1.
- Simultaneous shadow write and COMMIT cycle:
  - The commit uses the pre-write shadow value.
  - The new word lands in the shadow, and its dirty bit ends up set, not cleared.
- A commit with no dirty bits still occurs and still pulses frame_done.
- A CTRL write with bits[1:0] = 0 is a no-op.
- An arm write while already ARMED is a no-op.
- Reset mid-ARMED discards the pending commit.

Decomposition:
- Shared package: BASE default, offset constants (CTRL = 8, STATUS = 9), FSM state encoding (IDLE = 2'd0, ARMED = 2'd1, COMMIT = 2'd2).
- Sub-module: vs_edge_sync. It contains the 2-flop synchronizer plus the falling-edge detector, with output vs_fall. The frame counter stays in the top.

Test Plan:
1. Reset:
   - Stimulus: hold reset_n = 0 with vga_vs toggling.
   - Required: p1VGA = p2VGA = 0; frame_count = 0; STATUS read = 0.
2. Vsync commit:
   - Stimulus: write BASE+0 = 32'hDEADBEEF and BASE+3 = 32'h12345678, then CTRL = 1, then drive vga_vs low.
   - Required:
     - p1VGA == {32'h12345678, 64'h0, 32'hDEADBEEF} at t3.
     - p2VGA remains 0.
     - frame_done pulses exactly once.
     - STATUS dirty bits = 0.
3. No early commit:
   - Stimulus: shadow write plus arm, with vga_vs held high for 1000 cycles.
   - Required: live buses unchanged; STATUS bit2 = 1.
4. Force:
   - Stimulus: write BASE+4 = 32'hA5A5A5A5, then CTRL = 2 with vga_vs held high.
   - Required: p2VGA[31:0] = 32'hA5A5A5A5 at the next edge; state IDLE.
5. Collision:
   - Stimulus: write BASE+1 = 32'h1 in the exact COMMIT cycle.
   - Required: p1VGA[63:32] keeps its old value; STATUS dirty[0] = 1. The next armed vsync commits 32'h1.
6. Counter wrap and async reset:
   - Stimulus: FRAME_W = 4, then 17 VS falls.
   - Required: frame_count = 1.
   - Then assert reset_n mid-ARMED: outputs clear immediately, with no clock edge needed.
